// File: rtl/vga_sync_generator_if.sv
// ---------------------------------------------------------------------------
// vga_sync_generator_if
//
// Purpose:
//   Bundles the decoded VGA timing outputs of vga_sync_generator so that
//   they can be passed as one port to the pixel mux / VGA pin stage.
//
// Signals:
//   hsync, vsync   sync levels (stage 2)
//   video_on       inside the visible area (stage 2)
//   pixel_x/y      visible-area coordinates, 0 while blanked (stage 2)
//   img_addr       framebuffer read address (stage 1)
//   img_valid      BRAM data belongs to an in-window pixel (stage 2)
//   frame_start    pulse for count (0,0) (stage 2)
//   line_start     pulse for H=0 (stage 2)
//   frame_count    frame counter, only with VGA_SYNC_FRAME_CNT_EN defined
//
// Modports:
//   master  the sync generator, drives every signal
//   slave   the downstream consumer, reads every signal
// ---------------------------------------------------------------------------
interface vga_sync_generator_if #(
    parameter int ADDR_W = 17
);
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [ADDR_W-1:0] img_addr;
    logic              img_valid;
    logic              frame_start;
    logic              line_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0]       frame_count;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y,
        output img_addr, img_valid, frame_start, line_start,
        output frame_count
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y,
        input img_addr, img_valid, frame_start, line_start,
        input frame_count
    );
`else
    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y,
        output img_addr, img_valid, frame_start, line_start
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y,
        input img_addr, img_valid, frame_start, line_start
    );
`endif
endinterface

// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
//
// Purpose:
//   Decodes free-running horizontal/vertical counter values into registered
//   VGA sync, blanking and pixel-coordinate signals, and walks a framebuffer
//   read address across a rectangular image window. The address leaves at
//   stage 1 so it meets the BRAM address input; everything else leaves at
//   stage 2 so it lines up with the BRAM read data one cycle later.
//
// Ports:
//   clk_25MHz      in   pixel clock
//   reset          in   asynchronous, active-high
//   H_count_value  in   horizontal count, 0..H_TOTAL-1
//   V_count_value  in   vertical count, 0..V_TOTAL-1
//   vga            vga_sync_generator_if.master, all decoded outputs
//
// Configuration:
//   VGA_SYNC_FRAME_CNT_EN  when defined, adds vga.frame_count [15:0], a
//                          wrapping counter of frame_start pulses.
// ---------------------------------------------------------------------------
module vga_sync_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int IMG_X0   = 160,
    parameter int IMG_Y0   = 120,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17
) (
    input  logic                 clk_25MHz,
    input  logic                 reset,
    input  logic [9:0]           H_count_value,
    input  logic [9:0]           V_count_value,
    vga_sync_generator_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_TOTAL_C    = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C    = 10'(V_TOTAL);
    localparam logic [9:0] H_ACTIVE_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_C   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START_C   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START_C   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] WIN_X0_C     = 10'(IMG_X0);
    localparam logic [9:0] WIN_X1_C     = 10'(IMG_X0 + IMG_W);
    localparam logic [9:0] WIN_Y0_C     = 10'(IMG_Y0);
    localparam logic [9:0] WIN_Y1_C     = 10'(IMG_Y0 + IMG_H);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    // Stage 0 decode (combinational from the incoming counts)
    logic h_in_range;
    logic v_in_range;
    logic hsync_active;
    logic vsync_active;
    logic video_on_d;
    logic in_window_d;
    logic window_origin;
    logic frame_start_d;
    logic line_start_d;

    // Stage 1 registers
    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_video_on;
    logic [9:0]        s1_pixel_x;
    logic [9:0]        s1_pixel_y;
    logic              s1_in_window;
    logic              s1_frame_start;
    logic              s1_line_start;
    logic [ADDR_W-1:0] addr_q;
    logic              armed;

    // Stage 2 registers
    logic              s2_hsync;
    logic              s2_vsync;
    logic              s2_video_on;
    logic [9:0]        s2_pixel_x;
    logic [9:0]        s2_pixel_y;
    logic              s2_img_valid;
    logic              s2_frame_start;
    logic              s2_line_start;

    // Counts outside the legal frame are treated as blanking: both sync
    // windows require the pair to be in range, and since the image window
    // lies inside the visible area such counts never touch the address.
    always_comb begin
        h_in_range    = (H_count_value < H_TOTAL_C);
        v_in_range    = (V_count_value < V_TOTAL_C);
        hsync_active  = h_in_range && v_in_range &&
                        (H_count_value >= HS_START_C) &&
                        (H_count_value <= HS_END_C);
        vsync_active  = h_in_range && v_in_range &&
                        (V_count_value >= VS_START_C) &&
                        (V_count_value <= VS_END_C);
        video_on_d    = (H_count_value < H_ACTIVE_C) &&
                        (V_count_value < V_ACTIVE_C);
        in_window_d   = (H_count_value >= WIN_X0_C) &&
                        (H_count_value <  WIN_X1_C) &&
                        (V_count_value >= WIN_Y0_C) &&
                        (V_count_value <  WIN_Y1_C);
        window_origin = (H_count_value == WIN_X0_C) &&
                        (V_count_value == WIN_Y0_C);
        frame_start_d = (H_count_value == 10'd0) && (V_count_value == 10'd0);
        line_start_d  = (H_count_value == 10'd0) && v_in_range;
    end

    // Stage 1: register the decoded timing so it can travel alongside the
    // BRAM address for one cycle.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            s1_hsync       <= SYNC_IDLE;
            s1_vsync       <= SYNC_IDLE;
            s1_video_on    <= 1'b0;
            s1_pixel_x     <= '0;
            s1_pixel_y     <= '0;
            s1_in_window   <= 1'b0;
            s1_frame_start <= 1'b0;
            s1_line_start  <= 1'b0;
        end else begin
            s1_hsync       <= hsync_active ? SYNC_POL : SYNC_IDLE;
            s1_vsync       <= vsync_active ? SYNC_POL : SYNC_IDLE;
            s1_video_on    <= video_on_d;
            s1_pixel_x     <= video_on_d ? H_count_value : 10'd0;
            s1_pixel_y     <= video_on_d ? V_count_value : 10'd0;
            s1_in_window   <= in_window_d;
            s1_frame_start <= frame_start_d;
            s1_line_start  <= line_start_d;
        end
    end

    // Framebuffer address walker. The window is scanned in raster order, so
    // a counter that restarts at the origin and steps on every in-window
    // count reproduces (V-Y0)*W + (H-X0) without a multiplier. Because the
    // origin always reloads zero, the address never runs past the last
    // window pixel into the next frame.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (window_origin) begin
            addr_q <= '0;
        end else if (in_window_d) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // The address is only trustworthy once it has been reloaded at an
    // origin; until then img_valid is suppressed so no pixel is shown from
    // a stale address (e.g. after a reset released mid-frame).
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (window_origin) begin
            armed <= 1'b1;
        end
    end

    // Stage 2: final output registers, aligned with BRAM read data.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            s2_hsync       <= SYNC_IDLE;
            s2_vsync       <= SYNC_IDLE;
            s2_video_on    <= 1'b0;
            s2_pixel_x     <= '0;
            s2_pixel_y     <= '0;
            s2_img_valid   <= 1'b0;
            s2_frame_start <= 1'b0;
            s2_line_start  <= 1'b0;
        end else begin
            s2_hsync       <= s1_hsync;
            s2_vsync       <= s1_vsync;
            s2_video_on    <= s1_video_on;
            s2_pixel_x     <= s1_pixel_x;
            s2_pixel_y     <= s1_pixel_y;
            s2_img_valid   <= s1_in_window && armed;
            s2_frame_start <= s1_frame_start;
            s2_line_start  <= s1_line_start;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Steps on the same edge that raises frame_start, so the new count is
    // visible during the pulse. Wraps naturally at 16 bits.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (s1_frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vga.frame_count = frame_cnt_q;
`endif

    assign vga.hsync       = s2_hsync;
    assign vga.vsync       = s2_vsync;
    assign vga.video_on    = s2_video_on;
    assign vga.pixel_x     = s2_pixel_x;
    assign vga.pixel_y     = s2_pixel_y;
    assign vga.img_addr    = addr_q;
    assign vga.img_valid   = s2_img_valid;
    assign vga.frame_start = s2_frame_start;
    assign vga.line_start  = s2_line_start;

endmodule
